simd_op_sched: RTL

- Command scheduler/sequencer for the 64-lane SIMD array and its output mode mux (modes 0=MAC, 1=DIV, 2=EXP, 3=LOG).
- Accepts operation commands (mode, run length) through a valid/ready port and buffers them in a small FIFO.
- Sequences each command through clear, run and drain phases, drives the mux select, and presents a result-valid handshake for the consumer reading the selected oC lanes.

---
 rtl/simd_op_sched.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/simd_op_sched.sv
// simd_op_sched: command sequencer for the 64-lane SIMD array.
// Commands (mode, run length) are queued in a small FIFO and each one is
// walked through CLEAR -> RUN -> DRAIN -> DONE. The mux select, clear pulse,
// compute enable and result-valid are all registered, decoded from the
// next state, so they never glitch.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. cmd_ready depends only on the registered FIFO count.
// res_valid stays high, with res_mode stable, until res_ready is seen.
module simd_op_sched #(
    parameter int CNT_BW     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DRAIN_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [CNT_BW-1:0] cmd_len,
    output logic [1:0]        mode,
    output logic              clr,
    output logic              en,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [1:0]        res_mode,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DC_W  = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e            state_q, state_d;

    // Command FIFO storage and bookkeeping.
    logic [CNT_BW+1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              fifo_empty, fifo_full;
    logic              push, pop;
    logic [1:0]        head_mode;
    logic [CNT_BW-1:0] head_len;

    // Latched command and sequencing counters.
    logic [1:0]        mode_q;
    logic [CNT_BW-1:0] len_q;
    logic [CNT_BW-1:0] cnt_q;
    logic [DC_W-1:0]   dcnt_q;

    // Registered outputs and their next-state values.
    logic              clr_q, clr_d;
    logic              en_q, en_d;
    logic              res_valid_q, res_valid_d;
    logic [1:0]        res_mode_q, res_mode_d;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign cmd_ready  = !fifo_full;
    // A push coinciding with flush is dropped; pops only happen from IDLE.
    assign push       = cmd_valid && cmd_ready && !flush;
    assign pop        = (state_q == S_IDLE) && !fifo_empty && !flush;
    assign head_mode  = mem_q[rd_ptr_q][CNT_BW+1:CNT_BW];
    assign head_len   = mem_q[rd_ptr_q][CNT_BW-1:0];

    // FIFO payload write; storage needs no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_mode, cmd_len};
        end
    end

    // FIFO pointers and occupancy; flush empties the queue in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (!fifo_empty) state_d = S_CLEAR;
                S_CLEAR: state_d = (len_q != '0) ? S_RUN : S_DRAIN;
                S_RUN:   if (cnt_q == len_q - CNT_BW'(1)) state_d = S_DRAIN;
                S_DRAIN: if (dcnt_q == DC_W'(DRAIN_CYC - 1)) state_d = S_DONE;
                S_DONE:  if (res_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM output decode from the next state, so the registered outputs line up with it.
    always_comb begin
        clr_d       = (state_d == S_CLEAR);
        en_d        = (state_d == S_RUN);
        res_valid_d = (state_d == S_DONE);
        res_mode_d  = (state_d == S_DONE) ? mode_q : res_mode_q;
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_q       <= 1'b0;
            en_q        <= 1'b0;
            res_valid_q <= 1'b0;
            res_mode_q  <= 2'd0;
        end else begin
            clr_q       <= clr_d;
            en_q        <= en_d;
            res_valid_q <= res_valid_d;
            res_mode_q  <= res_mode_d;
        end
    end

    // Command latch and cycle counters; mode only changes when a new command starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 2'd0;
            len_q  <= '0;
            cnt_q  <= '0;
            dcnt_q <= '0;
        end else begin
            if (pop) begin
                mode_q <= head_mode;
                len_q  <= head_len;
            end
            if (flush || state_q == S_CLEAR) cnt_q <= '0;
            else if (state_q == S_RUN)       cnt_q <= cnt_q + CNT_BW'(1);
            if (!flush && state_q == S_DRAIN) dcnt_q <= dcnt_q + DC_W'(1);
            else                              dcnt_q <= '0;
        end
    end

    assign mode      = mode_q;
    assign clr       = clr_q;
    assign en        = en_q;
    assign res_valid = res_valid_q;
    assign res_mode  = res_mode_q;
    assign busy      = (state_q != S_IDLE) || !fifo_empty;
    assign dbg_state = state_q;

endmodule
